game_ctrl: RTL and testbench
============================

# game_ctrl

Game sequencer for the VGA ball game. It decides when the ball/bar physics datapath runs, when positions are reloaded, and when the lose screen shows. It also keeps the BCD score, lives and ball/bar speed. It sits between the VGA timing generator (which supplies `vs`), the physics/render block (which consumes `run`, `serve` and `speed`, and produces `hit`/`miss`) and the 7-segment score driver.

## Interface
Parameters:
- `SERVE_FRAMES`, 60: frames frozen before play starts after a serve.
- `MISS_FRAMES`, 90: frames frozen after a miss when lives remain.
- `SPEED_INIT`, 2: speed value loaded at game start.
- `SPEED_MAX`, 8: speed saturation value; must be at most 15.
- `HITS_PER_STEP`, 5: number of bar hits per speed increment; must be at least 1.
- `LIVES`, 3: lives per game, range 1–3.

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous and active-low.
- `vs` in 1: vertical sync level, synchronous to `clk`. Its rising edge is the frame tick.
- `start` in 1: player start button, already debounced. Its rising edge is used.
- `hit` in 1: one-cycle pulse, ball bounced off the bar.
- `miss` in 1: one-cycle pulse, ball passed below the bar.
- `run` out 1: physics enable.
- `serve` out 1: one-cycle pulse telling physics to reload the initial ball and bar positions.
- `lose` out 1: selects the lose screen.
- `speed` out 4: pixels per frame.
- `score_lo` out 4: BCD ones digit.
- `score_hi` out 4: BCD tens digit.
- `lives_left` out 2: lives remaining.

## Operation
- **Edge detection:** `vs` and `start` are each registered once. `tick = vs & ~vs_q`; `go = start & ~start_q`.
- **States:**
  - IDLE → SERVE on `go`. On this transition, score clears, `lives_left` is set to `LIVES`, `speed` is set to `SPEED_INIT` and the hit counter clears.
  - SERVE: `serve` pulses on the entry cycle. `frame_cnt` counts ticks. After `SERVE_FRAMES` ticks → PLAY.
  - PLAY: `run`=1.
    - `hit` increments the score and the hit counter.
    - `miss` decrements `lives_left`. If the result is 0 → OVER, otherwise → MISS.
  - MISS: `frame_cnt` counts ticks. After `MISS_FRAMES` ticks → SERVE. Score and speed are kept.
  - OVER: `lose`=1. On `go` → SERVE, with the same game reset as IDLE → SERVE.
- **`go` outside IDLE/OVER:** ignored.
- **`hit`/`miss` outside PLAY:** ignored.
- **`hit` and `miss` in the same cycle:** `miss` wins and the score is unchanged.
- **Score:** two cascaded BCD digits. `score_lo` 9 + hit → 0 and carries into `score_hi`. A score of 99 + hit wraps to 00.
- **Speed:** on the hit that brings the hit counter to `HITS_PER_STEP`, the counter clears and `speed` becomes min(`speed`+1, `SPEED_MAX`). `speed` never exceeds `SPEED_MAX`.
- **`frame_cnt`:** 7 bits; cleared on every state entry.
- **Reset values:** state IDLE; `run`=0, `serve`=0, `lose`=0; `speed`=`SPEED_INIT`; `score_lo`=`score_hi`=0; `lives_left`=`LIVES`; all internal counters and edge registers 0.

## Timing
- All outputs are registered.
- `run`, `lose` and `serve` change the cycle after the state register updates.
- Score, speed and lives update one cycle after the `hit`/`miss` sample.
- `run` falls 1 cycle after `miss` is sampled. The physics block may see at most one further frame edge.
- PLAY is entered exactly `SERVE_FRAMES` ticks after SERVE entry. The tick that arrives in the entry cycle does not count.
- Asserting `rst_n` mid-game returns to IDLE immediately, asynchronously. Outputs take their reset values the same instant.

## Configuration
- **`GAME_LIVES_EN` defined:** multi-life behaviour as described above.
- **`GAME_LIVES_EN` undefined:**
  - `LIVES` is ignored and `lives_left` is constant 0.
  - The first `miss` in PLAY goes directly to OVER.
  - MISS state and `MISS_FRAMES` logic are not generated.

## Structure
- **Package `game_pkg`:** state enum (IDLE, SERVE, PLAY, MISS, OVER, 3 bits) and the BCD digit width constant (4).
- **Sub-module `bcd_counter2`:** two-digit BCD counter with inputs `clk`, `rst_n`, `clr`, `inc` and outputs `lo`, `hi`, `wrap`. It is instantiated once for the score.

## Test plan
- Reset, then `start` edge → `serve` pulses once. After 60 `vs` rising edges, `run`=1; `speed`=2, `lives_left`=3, score 00.
- 5 `hit` pulses in PLAY → score 05, `speed`=3. A further 30 hits → score 35, `speed` saturates at 8.
- Preload score 98, then 2 hits → 99 followed by 00, with `score_hi` wrapping 9→0.
- `hit` and `miss` in the same cycle → score unchanged, `lives_left` 3→2, state MISS. After 90 ticks → SERVE, `serve` pulses.
- Three misses → OVER with `lose`=1 and `run`=0. `start` edge → SERVE with score 00, `lives_left`=3, `speed`=2. Repeat with `GAME_LIVES_EN` undefined: the first miss → OVER.
- `rst_n` pulsed low in PLAY mid-frame → all outputs at reset values the same instant. `hit` pulses in IDLE → no effect.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types and constants for the ball-game sequencer.
//   state_t : sequencer states (IDLE, SERVE, PLAY, MISS, OVER)
//   DIGIT_W : width of one BCD score digit
package game_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    MISS  = 3'd3,
    OVER  = 3'd4
  } state_t;

  localparam int unsigned DIGIT_W = 4;

endpackage

// File: rtl/bcd_counter2.sv
// Two-digit cascaded BCD counter (00..99, wraps to 00).
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear to 00 (has priority over inc)
//   inc        : count up by one
//   lo, hi     : ones and tens BCD digits
//   wrap       : one-cycle pulse registered alongside the 99 -> 00 roll-over
module bcd_counter2
  import game_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               inc,
  output logic [DIGIT_W-1:0] lo,
  output logic [DIGIT_W-1:0] hi,
  output logic               wrap
);

  localparam logic [DIGIT_W-1:0] NINE = DIGIT_W'(9);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo   <= '0;
      hi   <= '0;
      wrap <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (clr) begin
        lo <= '0;
        hi <= '0;
      end else if (inc) begin
        if (lo == NINE) begin
          lo <= '0;
          if (hi == NINE) begin
            hi   <= '0;
            wrap <= 1'b1;
          end else begin
            hi <= hi + 1'b1;
          end
        end else begin
          lo <= lo + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/game_ctrl.sv
// Game sequencer for the VGA ball game: gates the physics datapath, requests
// position reloads, selects the lose screen and keeps score, lives and speed.
// Build option: GAME_LIVES_EN enables multiple lives and the MISS pause; when
// undefined, lives_left is constant 0 and the first miss ends the game.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   vs                    : vertical sync level; rising edge = frame tick
//   start                 : debounced start button; rising edge used
//   hit, miss             : one-cycle pulses from the physics block
//   run                   : physics enable (registered)
//   serve                 : one-cycle reload pulse on SERVE entry (registered)
//   lose                  : lose-screen select (registered)
//   speed                 : pixels per frame
//   score_lo, score_hi    : BCD score digits
//   lives_left            : lives remaining
module game_ctrl
  import game_pkg::*;
#(
  parameter int unsigned SERVE_FRAMES  = 60,
  parameter int unsigned MISS_FRAMES   = 90,
  parameter int unsigned SPEED_INIT    = 2,
  parameter int unsigned SPEED_MAX     = 8,
  parameter int unsigned HITS_PER_STEP = 5,
  parameter int unsigned LIVES         = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               vs,
  input  logic               start,
  input  logic               hit,
  input  logic               miss,
  output logic               run,
  output logic               serve,
  output logic               lose,
  output logic [3:0]         speed,
  output logic [DIGIT_W-1:0] score_lo,
  output logic [DIGIT_W-1:0] score_hi,
  output logic [1:0]         lives_left
);

  if (SPEED_MAX > 15 || SPEED_INIT > SPEED_MAX || HITS_PER_STEP < 1 ||
      HITS_PER_STEP > 256 || LIVES < 1 || LIVES > 3 ||
      SERVE_FRAMES < 1 || SERVE_FRAMES > 128 ||
      MISS_FRAMES < 1 || MISS_FRAMES > 128) begin : g_bad_cfg
    $error("game_ctrl: parameter out of range");
  end

  localparam logic [6:0] SERVE_LAST = 7'(SERVE_FRAMES - 1);
  localparam logic [3:0] SPEED_RST  = 4'(SPEED_INIT);
  localparam logic [3:0] SPEED_TOP  = 4'(SPEED_MAX);
  localparam logic [7:0] HIT_LAST   = 8'(HITS_PER_STEP - 1);

  state_t     state_q, state_d;
  logic       vs_q, start_q;
  logic       tick, go;
  logic       entry_q;     // high during the first cycle spent in a state
  logic [6:0] frame_cnt;
  logic [7:0] hit_cnt;
  logic       game_rst;
  logic       hit_ok;
  logic       miss_ok;

  assign tick    = vs & ~vs_q;
  assign go      = start & ~start_q;
  assign miss_ok = (state_q == PLAY) && miss;
  // A simultaneous miss suppresses the hit.
  assign hit_ok  = (state_q == PLAY) && hit && !miss;

  always_comb begin
    state_d  = state_q;
    game_rst = 1'b0;
    case (state_q)
      IDLE, OVER: begin
        if (go) begin
          state_d  = SERVE;
          game_rst = 1'b1;
        end
      end
      // Ticks landing in the entry cycle are not counted.
      SERVE: begin
        if (tick && !entry_q && frame_cnt == SERVE_LAST) state_d = PLAY;
      end
      PLAY: begin
        if (miss) begin
`ifdef GAME_LIVES_EN
          state_d = (lives_left == 2'd1) ? OVER : MISS;
`else
          state_d = OVER;
`endif
        end
      end
`ifdef GAME_LIVES_EN
      MISS: begin
        if (tick && !entry_q && frame_cnt == 7'(MISS_FRAMES - 1)) state_d = SERVE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      entry_q   <= 1'b0;
      vs_q      <= 1'b0;
      start_q   <= 1'b0;
      frame_cnt <= '0;
      run       <= 1'b0;
      serve     <= 1'b0;
      lose      <= 1'b0;
    end else begin
      state_q <= state_d;
      entry_q <= (state_d != state_q);
      vs_q    <= vs;
      start_q <= start;
      if (state_d != state_q) begin
        frame_cnt <= '0;
      end else if (tick && !entry_q && (state_q == SERVE || state_q == MISS)) begin
        frame_cnt <= frame_cnt + 1'b1;
      end
      run   <= (state_q == PLAY);
      lose  <= (state_q == OVER);
      serve <= (state_q == SERVE) && entry_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      speed   <= SPEED_RST;
      hit_cnt <= '0;
    end else if (game_rst) begin
      speed   <= SPEED_RST;
      hit_cnt <= '0;
    end else if (hit_ok) begin
      if (hit_cnt == HIT_LAST) begin
        hit_cnt <= '0;
        if (speed < SPEED_TOP) speed <= speed + 1'b1;
      end else begin
        hit_cnt <= hit_cnt + 1'b1;
      end
    end
  end

`ifdef GAME_LIVES_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lives_left <= 2'(LIVES);
    end else if (game_rst) begin
      lives_left <= 2'(LIVES);
    end else if (miss_ok) begin
      lives_left <= lives_left - 1'b1;
    end
  end
`else
  assign lives_left = '0;
`endif

  bcd_counter2 u_score (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (game_rst),
    .inc  (hit_ok),
    .lo   (score_lo),
    .hi   (score_hi),
    .wrap ()
  );

endmodule

// File: tb/tb_game_ctrl.sv
module tb_game_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       vs = 1'b0;
  logic       start = 1'b0;
  logic       hit = 1'b0;
  logic       miss = 1'b0;
  logic       run, serve, lose;
  logic [3:0] speed, score_lo, score_hi;
  logic [1:0] lives_left;

  int checks = 0;
  int failures = 0;
  int serve_cnt = 0;

`ifdef GAME_LIVES_EN
  localparam int M_LIVES = 3;
`else
  localparam int M_LIVES = 0;
`endif

  // Reference model: game rules in plain arithmetic.
  int m_score, m_speed, m_hits, m_lives;

  game_ctrl #(
    .SERVE_FRAMES (60),
    .MISS_FRAMES  (90),
    .SPEED_INIT   (2),
    .SPEED_MAX    (8),
    .HITS_PER_STEP(5),
    .LIVES        (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .vs        (vs),
    .start     (start),
    .hit       (hit),
    .miss      (miss),
    .run       (run),
    .serve     (serve),
    .lose      (lose),
    .speed     (speed),
    .score_lo  (score_lo),
    .score_hi  (score_hi),
    .lives_left(lives_left)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (serve === 1'b1) serve_cnt++;

  function automatic logic [7:0] bcd(input int v);
    logic [7:0] r;
    r = {4'(v / 10), 4'(v % 10)};
    return r;
  endfunction

  task automatic model_new_game();
    m_score = 0; m_speed = 2; m_hits = 0; m_lives = M_LIVES;
  endtask

  task automatic model_hit();
    m_score = (m_score + 1) % 100;
    m_hits++;
    if (m_hits == 5) begin
      m_hits = 0;
      if (m_speed < 8) m_speed++;
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      vs = 1'b1; cycles($urandom_range(1, 3));
      vs = 1'b0; cycles($urandom_range(2, 3));
    end
  endtask

  task automatic pulse_hit();
    hit = 1'b1; cycles(1); hit = 1'b0;
    cycles($urandom_range(0, 2));
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cycles(2);
    checks++; if (run !== 1'b0) begin failures++; $display("FAIL reset_run got=%b exp=0", run); end
    checks++; if (serve !== 1'b0) begin failures++; $display("FAIL reset_serve got=%b exp=0", serve); end
    checks++; if (lose !== 1'b0) begin failures++; $display("FAIL reset_lose got=%b exp=0", lose); end
    checks++; if (speed !== 4'd2) begin failures++; $display("FAIL reset_speed got=%0d exp=2", speed); end
    checks++; if ({score_hi, score_lo} !== 8'h00) begin failures++; $display("FAIL reset_score got=%h exp=00", {score_hi, score_lo}); end
    checks++; if (lives_left !== 2'(M_LIVES)) begin failures++; $display("FAIL reset_lives got=%0d exp=%0d", lives_left, M_LIVES); end
    rst_n = 1'b1;
    cycles(2);
  endtask

  // Start edge, with a frame edge landing in SERVE's entry cycle that must not count.
  task automatic test_start_serve();
    int s0;
    s0 = serve_cnt;
    start = 1'b1; cycles(1);
    vs = 1'b1; cycles(1);
    start = 1'b0; vs = 1'b0; cycles(3);
    model_new_game();
    checks++; if (serve_cnt - s0 !== 1) begin failures++; $display("FAIL serve_pulse_count got=%0d exp=1", serve_cnt - s0); end
    frames(59);
    checks++; if (run !== 1'b0) begin failures++; $display("FAIL run_before_60 got=%b exp=0", run); end
    frames(1);
    checks++; if (run !== 1'b1) begin failures++; $display("FAIL run_after_60 got=%b exp=1", run); end
    checks++; if (speed !== 4'(m_speed)) begin failures++; $display("FAIL start_speed got=%0d exp=%0d", speed, m_speed); end
    checks++; if (lives_left !== 2'(m_lives)) begin failures++; $display("FAIL start_lives got=%0d exp=%0d", lives_left, m_lives); end
    checks++; if ({score_hi, score_lo} !== bcd(m_score)) begin failures++; $display("FAIL start_score got=%h exp=%h", {score_hi, score_lo}, bcd(m_score)); end
  endtask

  task automatic test_hits_speed();
    for (int i = 0; i < 35; i++) begin
      if ($urandom_range(0, 3) == 0) frames(1);
      pulse_hit();
      model_hit();
      checks++; if ({score_hi, score_lo} !== bcd(m_score)) begin failures++; $display("FAIL hit_score[%0d] got=%h exp=%h", i, {score_hi, score_lo}, bcd(m_score)); end
      checks++; if (speed !== 4'(m_speed)) begin failures++; $display("FAIL hit_speed[%0d] got=%0d exp=%0d", i, speed, m_speed); end
      if (i == 4) begin
        checks++; if (speed !== 4'd3) begin failures++; $display("FAIL speed_after_5 got=%0d exp=3", speed); end
      end
    end
    checks++; if (speed !== 4'd8) begin failures++; $display("FAIL speed_saturate got=%0d exp=8", speed); end
    checks++; if ({score_hi, score_lo} !== 8'h35) begin failures++; $display("FAIL score_35 got=%h exp=35", {score_hi, score_lo}); end
  endtask

  task automatic test_score_wrap();
    while (m_score != 98) begin
      pulse_hit();
      model_hit();
    end
    checks++; if ({score_hi, score_lo} !== 8'h98) begin failures++; $display("FAIL score_98 got=%h exp=98", {score_hi, score_lo}); end
    pulse_hit(); model_hit();
    checks++; if ({score_hi, score_lo} !== 8'h99) begin failures++; $display("FAIL score_99 got=%h exp=99", {score_hi, score_lo}); end
    pulse_hit(); model_hit();
    checks++; if ({score_hi, score_lo} !== 8'h00) begin failures++; $display("FAIL score_wrap got=%h exp=00", {score_hi, score_lo}); end
    checks++; if (speed !== 4'd8) begin failures++; $display("FAIL speed_hold_8 got=%0d exp=8", speed); end
  endtask

  task automatic miss_now();
    miss = 1'b1; cycles(1); miss = 1'b0;
    if (m_lives > 0) m_lives--;
    cycles(2);
  endtask

  task automatic test_hit_miss_same();
    int s0;
    pulse_hit(); model_hit();
    hit = 1'b1; miss = 1'b1; cycles(1); hit = 1'b0; miss = 1'b0;
    if (m_lives > 0) m_lives--;
    cycles(2);
    checks++; if ({score_hi, score_lo} !== bcd(m_score)) begin failures++; $display("FAIL hitmiss_score got=%h exp=%h", {score_hi, score_lo}, bcd(m_score)); end
    checks++; if (lives_left !== 2'(m_lives)) begin failures++; $display("FAIL hitmiss_lives got=%0d exp=%0d", lives_left, m_lives); end
    checks++; if (run !== 1'b0) begin failures++; $display("FAIL hitmiss_run got=%b exp=0", run); end
`ifdef GAME_LIVES_EN
    checks++; if (lose !== 1'b0) begin failures++; $display("FAIL miss_state_lose got=%b exp=0", lose); end
    pulse_hit();
    checks++; if ({score_hi, score_lo} !== bcd(m_score)) begin failures++; $display("FAIL hit_in_miss got=%h exp=%h", {score_hi, score_lo}, bcd(m_score)); end
    s0 = serve_cnt;
    frames(89);
    checks++; if (serve_cnt !== s0) begin failures++; $display("FAIL miss_early_serve got=%0d exp=%0d", serve_cnt, s0); end
    frames(1); cycles(1);
    checks++; if (serve_cnt !== s0 + 1) begin failures++; $display("FAIL miss_serve got=%0d exp=%0d", serve_cnt, s0 + 1); end
    frames(60);
    checks++; if (run !== 1'b1) begin failures++; $display("FAIL replay_run got=%b exp=1", run); end
    checks++; if (speed !== 4'(m_speed)) begin failures++; $display("FAIL speed_kept got=%0d exp=%0d", speed, m_speed); end
    miss_now();
    checks++; if (lives_left !== 2'(m_lives)) begin failures++; $display("FAIL lives_second got=%0d exp=%0d", lives_left, m_lives); end
    frames(90); frames(60);
    checks++; if (run !== 1'b1) begin failures++; $display("FAIL third_run got=%b exp=1", run); end
    miss_now();
`else
    s0 = serve_cnt;
`endif
    checks++; if (lose !== 1'b1) begin failures++; $display("FAIL over_lose got=%b exp=1", lose); end
    checks++; if (run !== 1'b0) begin failures++; $display("FAIL over_run got=%b exp=0", run); end
    checks++; if (lives_left !== 2'd0) begin failures++; $display("FAIL over_lives got=%0d exp=0", lives_left); end
  endtask

  task automatic test_over_ignores();
    pulse_hit();
    miss = 1'b1; cycles(1); miss = 1'b0; cycles(2);
    checks++; if ({score_hi, score_lo} !== bcd(m_score)) begin failures++; $display("FAIL over_hit got=%h exp=%h", {score_hi, score_lo}, bcd(m_score)); end
    checks++; if (lose !== 1'b1) begin failures++; $display("FAIL over_stays got=%b exp=1", lose); end
  endtask

  task automatic test_restart();
    int s0;
    s0 = serve_cnt;
    start = 1'b1; cycles(1); start = 1'b0; cycles(3);
    model_new_game();
    checks++; if (serve_cnt !== s0 + 1) begin failures++; $display("FAIL restart_serve got=%0d exp=%0d", serve_cnt, s0 + 1); end
    checks++; if (lose !== 1'b0) begin failures++; $display("FAIL restart_lose got=%b exp=0", lose); end
    checks++; if ({score_hi, score_lo} !== 8'h00) begin failures++; $display("FAIL restart_score got=%h exp=00", {score_hi, score_lo}); end
    checks++; if (lives_left !== 2'(m_lives)) begin failures++; $display("FAIL restart_lives got=%0d exp=%0d", lives_left, m_lives); end
    checks++; if (speed !== 4'd2) begin failures++; $display("FAIL restart_speed got=%0d exp=2", speed); end
    frames(60);
    checks++; if (run !== 1'b1) begin failures++; $display("FAIL restart_run got=%b exp=1", run); end
  endtask

  task automatic test_async_reset();
    int n;
    n = $urandom_range(6, 9);
    for (int i = 0; i < n; i++) begin pulse_hit(); model_hit(); end
    checks++; if ({score_hi, score_lo} !== bcd(m_score)) begin failures++; $display("FAIL prereset_score got=%h exp=%h", {score_hi, score_lo}, bcd(m_score)); end
    vs = 1'b1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    checks++; if (run !== 1'b0) begin failures++; $display("FAIL async_run got=%b exp=0", run); end
    checks++; if (serve !== 1'b0 || lose !== 1'b0) begin failures++; $display("FAIL async_serve_lose got=%b%b exp=00", serve, lose); end
    checks++; if (speed !== 4'd2) begin failures++; $display("FAIL async_speed got=%0d exp=2", speed); end
    checks++; if ({score_hi, score_lo} !== 8'h00) begin failures++; $display("FAIL async_score got=%h exp=00", {score_hi, score_lo}); end
    checks++; if (lives_left !== 2'(M_LIVES)) begin failures++; $display("FAIL async_lives got=%0d exp=%0d", lives_left, M_LIVES); end
    vs = 1'b0;
    cycles(2);
    rst_n = 1'b1;
    cycles(2);
  endtask

  task automatic test_idle_ignores();
    for (int i = 0; i < 3; i++) pulse_hit();
    miss = 1'b1; cycles(1); miss = 1'b0;
    frames(3);
    checks++; if ({score_hi, score_lo} !== 8'h00) begin failures++; $display("FAIL idle_hit_score got=%h exp=00", {score_hi, score_lo}); end
    checks++; if (run !== 1'b0 || lose !== 1'b0) begin failures++; $display("FAIL idle_run_lose got=%b%b exp=00", run, lose); end
    checks++; if (lives_left !== 2'(M_LIVES)) begin failures++; $display("FAIL idle_lives got=%0d exp=%0d", lives_left, M_LIVES); end
  endtask

  initial begin
    model_new_game();
    test_reset();
    test_start_serve();
    test_hits_speed();
    test_score_wrap();
    test_hit_miss_same();
    test_over_ignores();
    test_restart();
    test_async_reset();
    test_idle_ignores();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
